keypad_scan: RTL

//  Input-side companion to the multiplexed 7-seg display driver: scans a 4x4 hex matrix keypad.

---
 rtl/keypad_scan.sv | 136 +++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with frame debounce, single-key events and a 16-bit entry register.
// Define KEYPAD_REPEAT_EN to build auto-repeat of a held key; the default build has none.
module keypad_scan #(
    parameter int SCAN_DIV    = 1000,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    input  logic        i_clear,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic        o_key_down,
    output logic        o_key_multi,
    output logic [15:0] o_data
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STAB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DOWN = 2'd1;
    localparam logic [1:0] S_MULTI = 2'd2;

    if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("keypad_scan: parameter out of range");
    end

    logic [3:0]        r_row_s1, r_row_s2;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_col_sel;
    logic [11:0]       r_frame;
    logic [15:0]       r_prev, r_stable, r_data;
    logic [STAB_W-1:0] r_stab;
    logic [1:0]        r_state;
    logic              r_key_valid;
    logic [3:0]        r_key_code;

    logic              w_last, w_frame_done, w_settled, w_change, w_any, w_one, w_press, w_event;
    logic [15:0]       w_frame;
    logic [STAB_W-1:0] w_stab_next;
    logic [3:0]        w_code, w_event_code;
    logic [1:0]        w_state_next;

    assign w_last = r_div == DIV_LAST;
    assign w_frame_done = w_last && r_col_sel == 2'd3;
    // The last column is taken straight from the synchronizer so the frame is whole on its final sample.
    assign w_frame = {~r_row_s2, r_frame};
    assign w_stab_next = (w_frame != r_prev) ? STAB_W'(1) : (r_stab == STAB_MAX) ? r_stab : r_stab + 1'b1;
    assign w_settled = w_frame_done && w_stab_next == STAB_MAX;
    assign w_change = w_settled && w_frame != r_stable;
    assign w_any = |w_frame;
    assign w_one = w_any && ((w_frame & (w_frame - 16'd1)) == 16'd0);

    always_comb begin
        w_code = 4'h0;
        for (int i = 0; i < 16; i++)
            if (w_frame[i]) w_code = w_code | {i[1:0], i[3:2]};
    end

    assign w_state_next = !w_change ? r_state :
                          !w_any ? S_IDLE :
                          (r_state == S_IDLE && w_one) ? S_DOWN : S_MULTI;
    assign w_press = w_change && w_one && r_state == S_IDLE;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE;
    localparam int REP_W = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt, w_rep_next;
    logic             r_rep_first, w_repeat;

    assign w_rep_next = r_rep_cnt + 1'b1;
    assign w_repeat = w_frame_done && !w_change && r_state == S_DOWN &&
                      w_rep_next == (r_rep_first ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE));
    assign w_event = w_press || w_repeat;
    assign w_event_code = w_press ? w_code : r_key_code;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (r_state != S_DOWN || w_state_next != S_DOWN) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_frame_done) begin
            r_rep_cnt   <= w_repeat ? '0 : w_rep_next;
            r_rep_first <= r_rep_first && !w_repeat;
        end
`else
    assign w_event = w_press;
    assign w_event_code = w_code;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_row_s1    <= 4'hF;
            r_row_s2    <= 4'hF;
            r_div       <= '0;
            r_col_sel   <= 2'd0;
            r_frame     <= '0;
            r_prev      <= '0;
            r_stab      <= '0;
            r_stable    <= '0;
            r_state     <= S_IDLE;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_data      <= '0;
        end else begin
            r_row_s1    <= i_row;
            r_row_s2    <= r_row_s1;
            r_div       <= w_last ? '0 : r_div + 1'b1;
            if (w_last) r_col_sel <= r_col_sel + 1'b1;
            if (w_last && r_col_sel != 2'd3) r_frame[{r_col_sel, 2'b00} +: 4] <= ~r_row_s2;
            if (w_frame_done) begin
                r_prev <= w_frame;
                r_stab <= w_stab_next;
            end
            if (w_settled) r_stable <= w_frame;
            r_state     <= w_state_next;
            r_key_valid <= w_event;
            if (w_event) r_key_code <= w_event_code;
            r_data      <= w_event ? {i_clear ? 12'h000 : r_data[11:0], w_event_code} :
                           i_clear ? 16'h0000 : r_data;
        end

    assign o_col = ~(4'b0001 << r_col_sel);
    assign o_key_valid = r_key_valid;
    assign o_key_code = r_key_code;
    assign o_key_down = r_state == S_DOWN;
    assign o_key_multi = r_state == S_MULTI;
    assign o_data = r_data;
endmodule
